// File: rtl/dec_digit_scheduler.sv
// Shares one repeated-subtraction binary-to-BCD engine among NUM_REQ requesters
// using round-robin arbitration, writing {tens, ones} into a per-slot digit bank.
module dec_digit_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [8*NUM_REQ-1:0]   req_value_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic [8*NUM_REQ-1:0]   digits_out,
  output logic [NUM_REQ-1:0]     ovf_out,
  output logic                   busy_out,
  output logic                   done_pulse_out,
  output logic [PTR_W-1:0]       done_idx_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       idx_q, idx_d;
  logic [6:0]             rem_q, rem_d;
  logic [3:0]             tens_q, tens_d;
  logic [8*NUM_REQ-1:0]   digits_q, digits_d;
  logic [NUM_REQ-1:0]     ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic                   done_pulse_q, done_pulse_d;
  logic [PTR_W-1:0]       done_idx_q, done_idx_d;

  logic                   grant_found_s;
  logic [PTR_W-1:0]       grant_idx_s;
  logic [7:0]             grant_val_s;
  logic [NUM_REQ-1:0]     req_ready_s;

  // Round-robin search starting at rr_ptr_q, first valid slot wins.
  always_comb begin
    int cand;
    cand          = 0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    grant_val_s   = 8'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ((int'(rr_ptr_q) + k) >= NUM_REQ) ? (int'(rr_ptr_q) + k - NUM_REQ)
                                               : (int'(rr_ptr_q) + k);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found_s && (i == cand) && req_valid_in[i]) begin
          grant_found_s = 1'b1;
          grant_idx_s   = PTR_W'(i);
          grant_val_s   = req_value_in[8*i +: 8];
        end else begin
          grant_found_s = grant_found_s;
        end
      end
    end
  end

  always_comb begin
    req_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_s[i] = (state_q == IDLE) && grant_found_s && (grant_idx_s == PTR_W'(i));
    end
  end

  // Next-state logic for the FSM, conversion datapath and result bank.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    tens_d       = tens_q;
    digits_d     = digits_q;
    ovf_d        = ovf_q;
    busy_d       = 1'b0;
    done_pulse_d = 1'b0;
    done_idx_d   = done_idx_q;
    case (state_q)
      IDLE: begin
        if (grant_found_s) begin
          idx_d    = grant_idx_s;
          tens_d   = 4'd0;
          rr_ptr_d = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);
          state_d  = CONV;
          busy_d   = 1'b1;
          // Values above 99 saturate so the display shows 99 with the overflow flag.
          rem_d    = (grant_val_s > 8'd99) ? 7'd99 : grant_val_s[6:0];
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == PTR_W'(i)) begin
              ovf_d[i] = (grant_val_s > 8'd99);
            end else begin
              ovf_d[i] = ovf_q[i];
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (rem_q >= 7'd10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
          busy_d = 1'b1;
        end else begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (idx_q == PTR_W'(i)) begin
              digits_d[8*i +: 8] = {tens_q, rem_q[3:0]};
            end else begin
              digits_d[8*i +: 8] = digits_q[8*i +: 8];
            end
          end
          done_pulse_d = 1'b1;
          done_idx_d   = idx_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      idx_q        <= '0;
      rem_q        <= 7'd0;
      tens_q       <= 4'd0;
      digits_q     <= '0;
      ovf_q        <= '0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      done_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      idx_q        <= idx_d;
      rem_q        <= rem_d;
      tens_q       <= tens_d;
      digits_q     <= digits_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_pulse_q <= done_pulse_d;
      done_idx_q   <= done_idx_d;
    end
  end

  assign req_ready_out  = req_ready_s;
  assign digits_out     = digits_q;
  assign ovf_out        = ovf_q;
  assign busy_out       = busy_q;
  assign done_pulse_out = done_pulse_q;
  assign done_idx_out   = done_idx_q;

endmodule

// File: tb/tb_dec_digit_scheduler.sv
// Directed bench for dec_digit_scheduler: hand-computed digits, latencies and grant order.
module tb_dec_digit_scheduler;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 3;

  logic                 clk_in;
  logic                 rst_in;
  logic [NUM_REQ-1:0]   req_valid_in;
  logic [8*NUM_REQ-1:0] req_value_in;
  logic [NUM_REQ-1:0]   req_ready_out;
  logic [8*NUM_REQ-1:0] digits_out;
  logic [NUM_REQ-1:0]   ovf_out;
  logic                 busy_out;
  logic                 done_pulse_out;
  logic [PTR_W-1:0]     done_idx_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  dec_digit_scheduler #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_value_in   (req_value_in),
    .req_ready_out  (req_ready_out),
    .digits_out     (digits_out),
    .ovf_out        (ovf_out),
    .busy_out       (busy_out),
    .done_pulse_out (done_pulse_out),
    .done_idx_out   (done_idx_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, 64'(digits_out), 64'h0);
    chk({tag, "_ovf"},    64'(ovf_out), 64'h0);
    chk({tag, "_busy"},   64'(busy_out), 64'h0);
    chk({tag, "_done"},   64'(done_pulse_out), 64'h0);
    chk({tag, "_didx"},   64'(done_idx_out), 64'h0);
  endtask

  // Single-requester conversion: check ready, busy during conversion, latency, done index.
  task automatic conv(input string tag, input int slot, input logic [7:0] val, input int exp_lat);
    int n;
    req_value_in[8*slot +: 8] = val;
    req_valid_in = 4'(1 << slot);
    #1;
    chk({tag, "_ready"}, 64'(req_ready_out), 64'(1 << slot));
    tick();
    req_valid_in = 4'b0000;
    n = 1;
    while (!done_pulse_out && n < 20) begin
      chk({tag, "_busy"}, 64'(busy_out), 64'h1);
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_didx"}, 64'(done_idx_out), 64'(slot));
    chk({tag, "_busy_at_done"}, 64'(busy_out), 64'h0);
  endtask

  initial begin
    int order [5];
    int n;
    int pulses;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    rst_in       = 1'b1;
    req_valid_in = 4'b0000;
    req_value_in = 32'h0;
    tick();
    tick();
    rst_in = 1'b0;
    #1;
    chk_reset_outputs("reset");
    chk("reset_ready", 64'(req_ready_out), 64'h0);

    conv("s0_v0", 0, 8'd0, 2);
    chk("s0_v0_digits", 64'(digits_out), 64'h0000_0000);
    chk("s0_v0_ovf", 64'(ovf_out), 64'h0);

    conv("s1_v81", 1, 8'd81, 10);
    chk("s1_v81_digits", 64'(digits_out), 64'h0000_8100);

    conv("s2_v9", 2, 8'd9, 2);
    chk("s2_v9_digits", 64'(digits_out), 64'h0009_8100);

    conv("s2_v10", 2, 8'd10, 3);
    chk("s2_v10_digits", 64'(digits_out), 64'h0010_8100);

    conv("s3_v200", 3, 8'd200, 11);
    chk("s3_v200_digits", 64'(digits_out), 64'h9910_8100);
    chk("s3_v200_ovf", 64'(ovf_out), 64'h8);

    conv("s3_v42", 3, 8'd42, 6);
    chk("s3_v42_digits", 64'(digits_out), 64'h4210_8100);
    chk("s3_v42_ovf", 64'(ovf_out), 64'h0);

    // All four valid continuously from reset.
    rst_in       = 1'b1;
    req_value_in = {8'd99, 8'd0, 8'd23, 8'd5};
    req_valid_in = 4'b1111;
    tick();
    rst_in = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 64'(req_ready_out), 64'(1 << order[g]));
      chk("rr_onehot", 64'($onehot0(req_ready_out)), 64'h1);
      if (g > 0) begin
        chk("rr_b2b_done", 64'(done_pulse_out), 64'h1);
        chk("rr_b2b_didx", 64'(done_idx_out), 64'(order[g-1]));
      end
      tick();
      if (g == 4) req_valid_in = 4'b0000;
      n = 0;
      while (!done_pulse_out && n < 20) begin
        chk("rr_idle_ready", 64'(req_ready_out), 64'h0);
        tick();
        n++;
      end
      #1;
    end
    chk("rr_digits", 64'(digits_out), 64'h9900_2305);
    chk("rr_ovf", 64'(ovf_out), 64'h0);

    // Reset during conversion of 55 on slot 2 (rr_ptr moves to 3).
    req_value_in[23:16] = 8'd55;
    req_valid_in = 4'b0100;
    #1;
    chk("abort_ready", 64'(req_ready_out), 64'h4);
    tick();
    req_valid_in = 4'b0000;
    tick();
    chk("abort_busy", 64'(busy_out), 64'h1);
    rst_in = 1'b1;
    tick();
    chk_reset_outputs("abort");
    rst_in = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_pulse_out) pulses++;
      tick();
    end
    chk("abort_no_pulse", 64'(pulses), 64'h0);
    req_valid_in = 4'b1001;
    #1;
    chk("abort_rrptr0", 64'(req_ready_out), 64'h1);
    tick();
    req_valid_in = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
